rom_loader_fifo: RTL
====================

// Module: rom_loader_fifo
// PURPOSE
//  Generalised flash-to-SDRAM ROM copier; successor to the fixed-size loader.
//  - Fetches LEN words from flash word address BASE via the flash controller req/ack port.
//  - Buffers them in a prefetch FIFO so flash reads overlap SDRAM writes.
//  - Drains them to the SDRAM-side write handshake, starting at RAM byte address 0.
//  - Sits between the flash controller and the cart-download/SDRAM write logic in the top level.
// PARAMETERS
//  RAM_ADDR_W    25        SDRAM byte-address width.
//  FL_ADDR_W     23        flash word-address width.
//  DATA_W        16        word width, flash and SDRAM sides.
//  FIFO_DEPTH    4         prefetch entries; power of 2, >=2.
//  AUTO_START    1         1: begin a load of DEFAULT_WORDS from address 0 after reset release.
//  DEFAULT_WORDS 23'h200000 word count used by AUTO_START.
// PORTS
//  iclk           in   1           system clock
//  ireset_n       in   1           asynchronous active-low reset
//  istart         in   1           1-cycle pulse: start a load with ibase_addr/ilen
//  ibase_addr     in   FL_ADDR_W   first flash word address
//  ilen           in   FL_ADDR_W   word count; 0 = no load
//  oloading       out  1           high while a load is in progress
//  orom_load_wr   out  1           1-cycle write strobe
//  irom_load_wait in   1           SDRAM side busy
//  oram_addr      out  RAM_ADDR_W  byte address of current word; bit0 always 0
//  oram_wrdata    out  DATA_W      word to write
//  ofl_addr       out  FL_ADDR_W   flash word address
//  ofl_req        out  1           flash read request (level)
//  ifl_data       in   DATA_W      flash read data, valid with ifl_ack
//  ifl_ack        in   1           1-cycle flash read completion
//  ochecksum      out  16          ROM_LOADER_CHECKSUM_EN only
//  ochecksum_vld  out  1           ROM_LOADER_CHECKSUM_EN only
// BEHAVIOUR
//  Reset (async): all outputs 0, FIFO empty, fetch and write FSMs IDLE. Applies mid-load too:
//   - ofl_req drops immediately.
//   - No further writes are issued.
//  Start:
//   - istart is accepted only when oloading=0 and ilen!=0; otherwise ignored.
//   - On accept: oloading=1 next cycle; fetch ptr=ibase_addr; word counts=ilen; oram_addr=0.
//   - AUTO_START acts as one accepted istart (base 0, DEFAULT_WORDS) on the first cycle after reset release.
//  Fetch FSM IDLE->REQ->WAIT->(REQ|IDLE):
//   - REQ is entered only when the FIFO is not full and fetch words remain.
//   - In REQ/WAIT: ofl_req=1 and ofl_addr stays stable.
//   - On ifl_ack: ifl_data is pushed, ofl_addr+1, ofl_req=0 for at least one cycle.
//   - ifl_ack arriving while ofl_req=0 is ignored.
//  Write FSM IDLE->WR->GAP->(WR|DONE):
//   - WR (orom_load_wr=1 for exactly 1 cycle, oram_wrdata=FIFO head) needs FIFO not empty and irom_load_wait=0.
//   - GAP lasts 1 cycle with irom_load_wait ignored; then the FSM waits for irom_load_wait=0.
//   - oram_addr += 2 on the cycle after WR. After the last word it equals 2*len (ROM byte size).
//   - oram_addr holds its value until the next accepted start.
//  Completion: oloading falls the cycle after the last word's GAP once irom_load_wait=0.
//  FIFO: simultaneous push and pop allowed when full or empty; occupancy is unchanged.
//  Address arithmetic:
//   - ofl_addr wraps modulo 2^FL_ADDR_W.
//   - oram_addr wraps modulo 2^RAM_ADDR_W; no error is flagged.
// CONFIGURATION
//  ROM_LOADER_CHECKSUM_EN defined:
//   - Sums 16-bit words written at byte offsets >=0x200, modulo 2^16 (Genesis header checksum).
//   - The sum clears on accepted start.
//   - ochecksum_vld=1 from oloading fall until the next accepted start.
//  ROM_LOADER_CHECKSUM_EN undefined: ochecksum=0 and ochecksum_vld=0 constantly; no adder is built.
// TESTING
//  T1 AUTO_START with DEFAULT_WORDS=8; flash ack 3 cycles after req; wait never set
//     -> 8 writes with oram_addr 0,2,..,14; data matches flash; oloading falls; oram_addr=16.
//  T2 istart base=0x100 len=5; irom_load_wait held 10 cycles after each wr
//     -> 5 writes only; ofl_addr 0x100..0x104; FIFO stalls ofl_req after 4 prefetches.
//  T3 ilen=0 istart, and istart during an active load -> both ignored; oloading and counters unchanged.
//  T4 ireset_n low mid-load after word 3
//     -> outputs 0 immediately; after release with AUTO_START=0 no req and no wr until istart.
//  T5 ifl_ack pulse with no request outstanding
//     -> no FIFO push; the next write data still equals the correctly requested word.
//  T6 CHECKSUM_EN: len=0x102, word i=i
//     -> ochecksum = sum(0x100..0x101)=0x0201, ochecksum_vld=1 after oloading falls.

Source files
------------

// File: rtl/rom_loader_fifo.sv
// rom_loader_fifo
//   Copies LEN words from flash, starting at word address BASE, into SDRAM
//   starting at byte address 0. A small prefetch FIFO decouples the flash
//   read handshake from the SDRAM write handshake so the two can overlap.
//
// Optional feature macro: ROM_LOADER_CHECKSUM_EN
//   When defined, words written at byte offsets >= 0x200 are summed modulo
//   2^16 (Genesis header checksum) and reported once the load completes.
//   When undefined, ochecksum/ochecksum_vld are tied to 0 and no adder exists.
//
// Ports
//   iclk, ireset_n      clock, asynchronous active-low reset
//   istart              1-cycle start pulse, qualified by ibase_addr/ilen
//   ibase_addr, ilen    first flash word address and word count (0 = no load)
//   oloading            high while a load is in progress
//   orom_load_wr        1-cycle SDRAM write strobe
//   irom_load_wait      SDRAM side busy
//   oram_addr           SDRAM byte address of the current word (bit0 = 0)
//   oram_wrdata         word being written (0 outside the strobe)
//   ofl_addr, ofl_req   flash word address and level read request
//   ifl_data, ifl_ack   flash read data and 1-cycle completion
//   ochecksum(_vld)     header checksum and its valid flag
//
// Fetch FSM
//   state  | meaning
//   F_IDLE | no request; re-evaluates FIFO space and remaining words
//   F_REQ  | first cycle of a flash request
//   F_WAIT | request held, waiting for ifl_ack
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for FIFO data and irom_load_wait=0
//   W_WR   | write strobe, FIFO head popped
//   W_GAP  | mandatory 1-cycle spacing after a strobe
//   W_DONE | last word written, waiting for irom_load_wait=0 to finish

module rom_loader_fifo #(
  parameter int                   RAM_ADDR_W    = 25,
  parameter int                   FL_ADDR_W     = 23,
  parameter int                   DATA_W        = 16,
  parameter int                   FIFO_DEPTH    = 4,
  parameter bit                   AUTO_START    = 1'b1,
  parameter logic [FL_ADDR_W-1:0] DEFAULT_WORDS = 23'h200000
) (
  input  logic                  iclk,
  input  logic                  ireset_n,
  input  logic                  istart,
  input  logic [FL_ADDR_W-1:0]  ibase_addr,
  input  logic [FL_ADDR_W-1:0]  ilen,
  output logic                  oloading,
  output logic                  orom_load_wr,
  input  logic                  irom_load_wait,
  output logic [RAM_ADDR_W-1:0] oram_addr,
  output logic [DATA_W-1:0]     oram_wrdata,
  output logic [FL_ADDR_W-1:0]  ofl_addr,
  output logic                  ofl_req,
  input  logic [DATA_W-1:0]     ifl_data,
  input  logic                  ifl_ack,
  output logic [15:0]           ochecksum,
  output logic                  ochecksum_vld
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WR   = 2'd1,
    W_GAP  = 2'd2,
    W_DONE = 2'd3
  } write_state_t;

  fetch_state_t r_fstate, w_fnext;
  write_state_t r_wstate, w_wnext;

  logic                  r_loading;
  logic                  r_auto_pend;
  logic [FL_ADDR_W-1:0]  r_fl_addr;
  logic [FL_ADDR_W-1:0]  r_fetch_left;
  logic [FL_ADDR_W-1:0]  r_wr_left;
  logic [RAM_ADDR_W-1:0] r_ram_addr;

  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_auto_go;
  logic                  w_user_go;
  logic                  w_accept;
  logic [FL_ADDR_W-1:0]  w_start_base;
  logic [FL_ADDR_W-1:0]  w_start_len;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_ack;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_finish;
  logic [DATA_W-1:0]     w_head;

  // ---------------------------------------------------------------------------
  // Start qualification. The auto-start pulse exists only on the first cycle
  // after reset release and takes priority over a coincident istart.
  // ---------------------------------------------------------------------------
  assign w_auto_go    = r_auto_pend && (DEFAULT_WORDS != '0);
  assign w_user_go    = istart && (ilen != '0);
  assign w_accept     = !r_loading && (w_auto_go || w_user_go);
  assign w_start_base = w_auto_go ? '0 : ibase_addr;
  assign w_start_len  = w_auto_go ? DEFAULT_WORDS : ilen;

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // An ack only counts while a request is outstanding; stray acks are dropped.
  assign w_ack  = ifl_ack && (r_fstate != F_IDLE);
  assign w_push = w_ack;
  assign w_pop  = (r_wstate == W_WR);

  always_ff @(posedge iclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ifl_data;
    end
  end

  // Push with pop on a full FIFO is safe: the head is read combinationally
  // before the write lands. A pop is never issued on an empty FIFO because
  // W_WR is only entered with data present.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM. Returning to F_IDLE after every ack guarantees ofl_req drops for
  // at least one cycle between reads. Only one read is ever outstanding and
  // F_REQ requires a free slot, so the push on ack can never overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fnext = r_fstate;
    case (r_fstate)
      F_IDLE: begin
        if (r_loading && (r_fetch_left != '0) && !w_full) begin
          w_fnext = F_REQ;
        end
      end
      F_REQ: begin
        w_fnext = w_ack ? F_IDLE : F_WAIT;
      end
      F_WAIT: begin
        if (w_ack) begin
          w_fnext = F_IDLE;
        end
      end
      default: w_fnext = F_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write FSM. r_wr_left is already decremented when W_GAP is reached, so zero
  // there means the word just written was the last one.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wnext  = r_wstate;
    w_finish = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (r_loading && (r_wr_left != '0) && !w_empty && !irom_load_wait) begin
          w_wnext = W_WR;
        end
      end
      W_WR: begin
        w_wnext = W_GAP;
      end
      W_GAP: begin
        if (r_wr_left == '0) begin
          if (!irom_load_wait) begin
            w_finish = 1'b1;
            w_wnext  = W_IDLE;
          end else begin
            w_wnext = W_DONE;
          end
        end else if (!w_empty && !irom_load_wait) begin
          w_wnext = W_WR;
        end else begin
          w_wnext = W_IDLE;
        end
      end
      W_DONE: begin
        if (!irom_load_wait) begin
          w_finish = 1'b1;
          w_wnext  = W_IDLE;
        end
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_fstate <= F_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_fstate <= w_fnext;
      r_wstate <= w_wnext;
    end
  end

  // ---------------------------------------------------------------------------
  // Load bookkeeping. Accept and the ack/pop updates are mutually exclusive:
  // accept needs oloading=0, which implies both FSMs are idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_loading    <= 1'b0;
      r_auto_pend  <= AUTO_START;
      r_fl_addr    <= '0;
      r_fetch_left <= '0;
      r_wr_left    <= '0;
      r_ram_addr   <= '0;
    end else begin
      r_auto_pend <= 1'b0;
      if (w_accept) begin
        r_loading    <= 1'b1;
        r_fl_addr    <= w_start_base;
        r_fetch_left <= w_start_len;
        r_wr_left    <= w_start_len;
        r_ram_addr   <= '0;
      end else begin
        if (w_finish) begin
          r_loading <= 1'b0;
        end
        if (w_ack) begin
          r_fl_addr    <= r_fl_addr + FL_ADDR_W'(1);
          r_fetch_left <= r_fetch_left - FL_ADDR_W'(1);
        end
        if (w_pop) begin
          r_wr_left  <= r_wr_left - FL_ADDR_W'(1);
          r_ram_addr <= r_ram_addr + RAM_ADDR_W'(2);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign oloading     = r_loading;
  assign orom_load_wr = w_pop;
  assign oram_wrdata  = w_pop ? w_head : '0;
  assign oram_addr    = r_ram_addr;
  assign ofl_addr     = r_fl_addr;
  assign ofl_req      = (r_fstate != F_IDLE);

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] r_csum;
  logic        r_csum_vld;

  // The header occupies bytes 0..0x1FF and is excluded from the sum.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_csum     <= '0;
      r_csum_vld <= 1'b0;
    end else begin
      if (w_accept) begin
        r_csum     <= '0;
        r_csum_vld <= 1'b0;
      end else begin
        if (w_pop && (r_ram_addr >= RAM_ADDR_W'(12'h200))) begin
          r_csum <= r_csum + 16'(w_head);
        end
        if (w_finish) begin
          r_csum_vld <= 1'b1;
        end
      end
    end
  end

  assign ochecksum     = r_csum;
  assign ochecksum_vld = r_csum_vld;
`else
  assign ochecksum     = 16'h0000;
  assign ochecksum_vld = 1'b0;
`endif

endmodule
